// File: rtl/eth10_pkg.sv
// Shared definitions for the 10BASE-T transmit path.
// Holds the transmit-line scheduler state type, the default timing
// constants for a 20 MHz clock, and a small constant helper.
package eth10_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NLP,
    ST_GRANT,
    ST_FRAME,
    ST_TPIDL,
    ST_IPG
  } state_t;

  localparam int unsigned NLP_PERIOD  = 320000; // 16 ms between link pulses
  localparam int unsigned NLP_WIDTH   = 2;      // 100 ns link pulse
  localparam int unsigned TPIDL_WIDTH = 5;      // 250 ns end-of-frame idle
  localparam int unsigned IPG_LEN     = 192;    // 9.6 us inter-packet gap
  localparam int unsigned MAX_FRAME   = 24400;  // frame watchdog limit

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nlp_timer.sv
// Free-running link-pulse interval timer.
// Counts enabled cycles and flags expire when the count reaches PERIOD-1;
// the count restarts from zero on expiry or on an explicit clear.
// Ports:
//   clk, resetn  clock, synchronous active-low reset
//   clear        restart the interval from zero
//   enable       count this cycle
//   expire       interval complete (combinational from the count)
module nlp_timer #(
  parameter int unsigned PERIOD = 320000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [W-1:0] count;

  assign expire = enable && (count == W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count <= '0;
    end else if (expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tx_line_sched.sv
// Transmit-line scheduler: shares the TD output between periodic normal
// link pulses and frames from the Manchester serializer.
// Each frame runs grant -> data -> TP_IDL -> inter-packet gap; the link
// pulse interval restarts at TP_IDL entry.
// Ports:
//   clk, resetn  20 MHz clock, synchronous active-low reset
//   req          serializer line request (level, held until go)
//   man_in       Manchester stream, valid in FRAME
//   last         pulse with the final half-bit of the frame
//   go           one-cycle grant pulse
//   Tx           line output (registered)
//   tx_en        high while frame data is on the line
//   abort        one-cycle pulse on watchdog expiry
module tx_line_sched #(
  parameter int unsigned NLP_PERIOD  = eth10_pkg::NLP_PERIOD,
  parameter int unsigned NLP_WIDTH   = eth10_pkg::NLP_WIDTH,
  parameter int unsigned TPIDL_WIDTH = eth10_pkg::TPIDL_WIDTH,
  parameter int unsigned IPG_LEN     = eth10_pkg::IPG_LEN,
  parameter int unsigned MAX_FRAME   = eth10_pkg::MAX_FRAME
) (
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic man_in,
  input  logic last,
  output logic go,
  output logic Tx,
  output logic tx_en,
  output logic abort
);

  import eth10_pkg::*;

  localparam int unsigned PH_MAX = max2(max2(NLP_WIDTH, TPIDL_WIDTH),
                                        max2(IPG_LEN, MAX_FRAME));
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_t          state, state_nxt;
  logic [PH_W-1:0] phase;
  logic            last_seen;
  logic            expire;
  logic            nlp_clr;
  logic            go_nxt, tx_nxt, tx_en_nxt, abort_nxt;

  // The link-pulse interval restarts whenever TP_IDL begins.
  assign nlp_clr = (state_nxt == ST_TPIDL) && (state != ST_TPIDL);

  nlp_timer #(
    .PERIOD(NLP_PERIOD)
  ) u_nlp_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (nlp_clr),
    .enable (1'b1),
    .expire (expire)
  );

  always_comb begin
    state_nxt = state;
    abort_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (expire) begin
          state_nxt = ST_NLP;
        end else if (req) begin
          state_nxt = ST_GRANT;
        end
      end
      ST_NLP: begin
        if (phase == PH_W'(NLP_WIDTH - 1)) state_nxt = ST_IDLE;
      end
      ST_GRANT: state_nxt = ST_FRAME;
      ST_FRAME: begin
        // The cycle that samples last still launches man_in onto the
        // registered Tx, so the frame is left one cycle after last.
        if (last_seen) begin
          state_nxt = ST_TPIDL;
        end else if (!last && (phase == PH_W'(MAX_FRAME - 1))) begin
          state_nxt = ST_TPIDL;
          abort_nxt = 1'b1;
        end
      end
      ST_TPIDL: begin
        if (phase == PH_W'(TPIDL_WIDTH - 1)) state_nxt = ST_IPG;
      end
      ST_IPG: begin
        if (phase == PH_W'(IPG_LEN - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    go_nxt    = (state_nxt == ST_GRANT);
    tx_en_nxt = (state_nxt == ST_FRAME);
    case (state_nxt)
      ST_NLP, ST_TPIDL: tx_nxt = 1'b1;
      ST_FRAME:         tx_nxt = man_in;
      default:          tx_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      phase     <= '0;
      last_seen <= 1'b0;
      go        <= 1'b0;
      Tx        <= 1'b0;
      tx_en     <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nxt;
      if ((state_nxt != state) || (state == ST_IDLE)) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
      last_seen <= (state == ST_FRAME) && (state_nxt == ST_FRAME) && last;
      go        <= go_nxt;
      Tx        <= tx_nxt;
      tx_en     <= tx_en_nxt;
      abort     <= abort_nxt;
    end
  end

endmodule
